// File: rtl/rf_pkg.sv
// Shared types, constants and write-port arbitration for the multi-port
// register file and its scoreboard.
package rf_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;

    // Arbitration works on port/address vectors widened to these
    // maxima so one function serves every instance size.
    localparam int MAX_WR   = 8;
    localparam int MAX_AW   = 8;
    localparam int WR_IDX_W = $clog2(MAX_WR);

    typedef logic [MAX_AW-1:0] ext_addr_t;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_win_t;

    // Highest-index enabled port writing addr wins; x0 never hits.
    function automatic wr_win_t wr_winner(
        input logic      [MAX_WR-1:0] we,
        input ext_addr_t [MAX_WR-1:0] waddr,
        input ext_addr_t              addr
    );
        wr_win_t r;
        r = '0;
        if (addr != ext_addr_t'(ZERO_REG)) begin
            for (int k = 0; k < MAX_WR; k++) begin
                if (we[k] && (waddr[k] == addr)) begin
                    r.hit = 1'b1;
                    r.idx = WR_IDX_W'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer bit per register. Ports: clk, reset_n, set_i/set_addr_i
// (issue), clr_i (writeback clears), flush_i, q_addr_i -> q_pend_o (lookups).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W_DEF,
    parameter int NUM_Q      = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        set_i,
    input  logic [ADDR_WIDTH-1:0]       set_addr_i,
    input  logic [(2**ADDR_WIDTH)-1:0]  clr_i,
    input  logic                        flush_i,
    input  logic [NUM_Q*ADDR_WIDTH-1:0] q_addr_i,
    output logic [NUM_Q-1:0]            q_pend_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Flush beats everything; a new producer beats a same-cycle clear.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else begin
            pend_d = pend_q & ~clr_i;
            if (set_i && (set_addr_i != '0)) begin
                pend_d[set_addr_i] = 1'b1;
            end
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar j = 0; j < NUM_Q; j++) begin : g_q
        assign q_pend_o[j] = pend_q[q_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with scoreboard and optional bypass.
// Ports: we/waddr/wdata (NUM_WR write ports), raddr -> rdata/rd_pending
// (NUM_RD async reads), sb_set/sb_addr/sb_flush (scoreboard control).
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ADDR_WIDTH = REG_ADDR_W_DEF,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*XLEN-1:0]       wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*XLEN-1:0]       rdata,
    output logic [NUM_RD-1:0]            rd_pending,
    input  logic                         sb_set,
    input  logic [ADDR_WIDTH-1:0]        sb_addr,
    input  logic                         sb_flush
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];

    logic [MAX_WR-1:0]            we_ext;
    ext_addr_t [MAX_WR-1:0]       wa_ext;
    logic [XLEN-1:0]              wd_arr [MAX_WR];
    logic [DEPTH-1:0]             clr;
    logic [NUM_RD-1:0]            q_pend;

    // Widen the write ports to the arbiter's fixed size; spare ports idle.
    for (genvar k = 0; k < MAX_WR; k++) begin : g_wr
        if (k < NUM_WR) begin : g_on
            assign we_ext[k] = we[k];
            assign wa_ext[k] = ext_addr_t'(waddr[k*ADDR_WIDTH +: ADDR_WIDTH]);
            assign wd_arr[k] = wdata[k*XLEN +: XLEN];
        end else begin : g_off
            assign we_ext[k] = 1'b0;
            assign wa_ext[k] = '0;
            assign wd_arr[k] = '0;
        end
    end

    // Ascending port order lets the highest index overwrite earlier ones.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we[k]) begin
                mem_d[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] =
                    wdata[k*XLEN +: XLEN];
            end
        end
        mem_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        clr = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (we[k]) begin
                clr[waddr[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
        clr[ZERO_REG] = 1'b0;
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_Q      (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_i      (sb_set),
        .set_addr_i (sb_addr),
        .clr_i      (clr),
        .flush_i    (sb_flush),
        .q_addr_i   (raddr),
        .q_pend_o   (q_pend)
    );

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        wr_win_t               win;
        logic                  byp_hit;
        logic                  same_set;
        logic [XLEN-1:0]       rd_val;

        assign ra       = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
        assign win      = wr_winner(we_ext, wa_ext, ext_addr_t'(ra));
        assign byp_hit  = (BYPASS != 0) && win.hit;
        assign same_set = sb_set && (sb_addr == ra);
        assign rd_val   = byp_hit ? wd_arr[win.idx] : mem_q[ra];

        // Held at zero in reset so a bypassed write cannot leak through.
        assign rdata[j*XLEN +: XLEN] = reset_n ? rd_val : '0;
        // A retiring producer unmasks early unless a new one is issuing.
        assign rd_pending[j] = reset_n && q_pend[j]
                               && !(byp_hit && !same_set);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: bypass and non-bypass instances share stimulus
// and are compared against an array-based reference model.
module tb_reg_file_mp;

    localparam int XL = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int D  = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*XL-1:0] wdata;
    logic [NR*AW-1:0] raddr;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic             sb_flush;
    logic [NR*XL-1:0] rdata_b, rdata_n;
    logic [NR-1:0]    pend_b, pend_n;

    int n_vec = 0;
    int n_bad = 0;

    logic [XL-1:0] m_mem  [D];
    bit            m_pend [D];

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XL), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .BYPASS(1)) u_byp (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata_b),
        .rd_pending(pend_b), .sb_set(sb_set), .sb_addr(sb_addr),
        .sb_flush(sb_flush));

    reg_file_mp #(.XLEN(XL), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                  .BYPASS(0)) u_nob (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata_n),
        .rd_pending(pend_n), .sb_set(sb_set), .sb_addr(sb_addr),
        .sb_flush(sb_flush));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] wa(int k);
        return waddr[k*AW +: AW];
    endfunction

    function automatic logic [XL-1:0] wd(int k);
        return wdata[k*XL +: XL];
    endfunction

    function automatic logic [AW-1:0] ra_of(int j);
        return raddr[j*AW +: AW];
    endfunction

    function automatic logic [31:0] exp_rd(logic [AW-1:0] ra, bit byp);
        logic [31:0] v;
        if (!reset_n || ra == '0) return '0;
        v = m_mem[ra];
        if (byp)
            for (int k = 0; k < NW; k++)
                if (we[k] && wa(k) == ra) v = wd(k);
        return v;
    endfunction

    function automatic bit exp_pd(logic [AW-1:0] ra, bit byp);
        bit p;
        if (!reset_n || ra == '0) return 1'b0;
        p = m_pend[ra];
        if (byp && !(sb_set && sb_addr == ra))
            for (int k = 0; k < NW; k++)
                if (we[k] && wa(k) == ra) p = 1'b0;
        return p;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < D; a++) begin
            m_mem[a]  = '0;
            m_pend[a] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit cl [D];
        for (int a = 0; a < D; a++) cl[a] = 1'b0;
        for (int k = 0; k < NW; k++)
            if (we[k] && wa(k) != '0) begin
                m_mem[wa(k)] = wd(k);
                cl[wa(k)]    = 1'b1;
            end
        if (sb_flush) begin
            for (int a = 0; a < D; a++) m_pend[a] = 1'b0;
        end else begin
            for (int a = 0; a < D; a++) if (cl[a]) m_pend[a] = 1'b0;
            if (sb_set && sb_addr != '0) m_pend[sb_addr] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < NR; j++) begin
            chk($sformatf("rd_b%0d", j), rdata_b[j*XL +: XL],
                exp_rd(ra_of(j), 1'b1));
            chk($sformatf("rd_n%0d", j), rdata_n[j*XL +: XL],
                exp_rd(ra_of(j), 1'b0));
            chk($sformatf("pd_b%0d", j), 32'(pend_b[j]),
                32'(exp_pd(ra_of(j), 1'b1)));
            chk($sformatf("pd_n%0d", j), 32'(pend_n[j]),
                32'(exp_pd(ra_of(j), 1'b0)));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        sb_set = 1'b0; sb_addr = '0; sb_flush = 1'b0;
    endtask

    task automatic wr(int k, logic [AW-1:0] a, logic [31:0] d);
        we[k] = 1'b1;
        waddr[k*AW +: AW] = a;
        wdata[k*XL +: XL] = d;
    endtask

    task automatic rd(int j, logic [AW-1:0] a);
        raddr[j*AW +: AW] = a;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        raddr = NR*AW'($urandom);
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: mid-cycle reset drops stored data at once
        idle(); wr(0, 5'd5, 32'h1234); rd(0, 5'd5); rd(1, 5'd9); rd(2, 5'd0);
        sb_set = 1'b1; sb_addr = 5'd9;
        cyc();
        idle();
        #2;
        chk("t1_pre", rdata_n[31:0], 32'h1234);
        chk("t1_prepd", 32'(pend_n[1]), 32'd1);
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("t1_rst", rdata_b[31:0], 32'h0);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;

        // T2: x0 ignores writes and scoreboard sets
        idle(); wr(0, 5'd0, 32'hDEADBEEF); sb_set = 1'b1; sb_addr = 5'd0;
        rd(0, 5'd0); rd(1, 5'd0); rd(2, 5'd0);
        cyc();
        idle();
        cyc();
        chk("t2_x0", rdata_b[31:0], 32'h0);

        // T3: same-address collision, port 1 wins
        idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7);
        #1;
        chk("t3_byp", rdata_b[31:0], 32'h22);
        chk("t3_nob", rdata_n[31:0], 32'h0);
        cyc();
        idle();
        cyc();
        chk("t3_next", rdata_n[31:0], 32'h22);

        // T4: write x3 while reading it
        idle(); wr(0, 5'd3, 32'hA5); rd(1, 5'd3);
        cyc();
        idle();
        cyc();
        chk("t4_next", rdata_n[63:32], 32'hA5);

        // T5: scoreboard set / set-beats-clear / clear
        idle(); sb_set = 1'b1; sb_addr = 5'd9; rd(0, 5'd9);
        cyc();
        idle(); wr(1, 5'd9, 32'h99); sb_set = 1'b1; sb_addr = 5'd9;
        #1;
        chk("t5_setclr", 32'(pend_b[0]), 32'd1);
        cyc();
        idle(); wr(0, 5'd9, 32'h9A);
        #1;
        chk("t5_byclr", 32'(pend_b[0]), 32'd0);
        chk("t5_nbclr", 32'(pend_n[0]), 32'd1);
        cyc();
        idle();
        cyc();

        // T6: flush clears everything, even a coincident set
        idle(); sb_set = 1'b1; sb_addr = 5'd4; cyc();
        sb_addr = 5'd8; cyc();
        sb_addr = 5'd12; wr(0, 5'd4, 32'h44); cyc();
        idle(); rd(0, 5'd4); rd(1, 5'd8); rd(2, 5'd12);
        cyc();
        idle(); sb_flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd2;
        cyc();
        idle(); rd(2, 5'd2);
        cyc();
        chk("t6_pd8", 32'(pend_n[1]), 32'd0);
        chk("t6_pd2", 32'(pend_n[2]), 32'd0);
        chk("t6_data", rdata_n[31:0], 32'h44);

        // Random traffic over a narrow address window to force conflicts
        for (int c = 0; c < 600; c++) begin
            idle();
            for (int k = 0; k < NW; k++)
                if ($urandom_range(0, 1) == 1)
                    wr(k, AW'($urandom_range(0, 7)), $urandom);
            for (int j = 0; j < NR; j++)
                rd(j, ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                                  : AW'($urandom_range(0, 7)));
            sb_set   = ($urandom_range(0, 2) == 0);
            sb_addr  = AW'($urandom_range(0, 7));
            sb_flush = ($urandom_range(0, 24) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
